// File: rtl/rx_oversample_sampler_pkg.sv
// Shared UART RX definitions: sampling-mode encodings, reset defaults and
// the legal oversampling ratios.
package uart_rx_defs;

  typedef enum logic [1:0] {
    SAMP_1TAP = 2'b00,
    SAMP_3TAP = 2'b01,
    SAMP_5TAP = 2'b10,
    SAMP_RSVD = 2'b11
  } samp_mode_e;

  localparam int unsigned PRESCALE_4   = 4;
  localparam int unsigned PRESCALE_8   = 8;
  localparam int unsigned PRESCALE_16  = 16;
  localparam int unsigned PRESCALE_32  = 32;

  localparam int unsigned PRESCALE_DEF = PRESCALE_8;
  localparam samp_mode_e  MODE_DEF     = SAMP_3TAP;

endpackage

// File: rtl/rx_oversample_sampler_vote.sv
// Combinational majority vote over 1, 3 or 5 taps (k = 0/1/2), with a flag
// for non-unanimous taps. Also usable for the start-bit check.
module rx_majority_vote (
  input  logic [4:0] samples_i,
  input  logic [1:0] k_i,
  output logic       vote_o,
  output logic       noise_o
);

  logic [4:0] mask;
  logic [4:0] masked;
  logic [2:0] pop;
  logic [2:0] n_taps;

  always_comb begin
    case (k_i)
      2'd0:    mask = 5'b00001;
      2'd1:    mask = 5'b00111;
      default: mask = 5'b11111;
    endcase
    masked = samples_i & mask;
    pop    = '0;
    for (int unsigned i = 0; i < 5; i++) begin
      pop = pop + 3'(masked[i]);
    end
    n_taps  = {k_i, 1'b1};
    vote_o  = (pop > {1'b0, k_i});
    noise_o = (pop != '0) && (pop != n_taps);
  end

endmodule

// File: rtl/rx_oversample_sampler.sv
// UART RX oversampling bit sampler: per-bit edge counter, mid-bit tap capture
// and majority vote with a noise flag.
module rx_oversample_sampler
  import uart_rx_defs::*;
#(
  parameter int unsigned PRESCALE_WD = 6
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [PRESCALE_WD-1:0] prescale,
  input  logic [1:0]             samp_mode,
  input  logic                   samp_en,
  input  logic                   bit_start,
  input  logic                   RX_IN,
  output logic [PRESCALE_WD-1:0] edge_count,
  output logic                   sampled_bit,
  output logic                   sampling_done,
  output logic                   noise_err
);

  typedef logic [PRESCALE_WD-1:0] cnt_t;

  cnt_t       edge_q, edge_d;
  cnt_t       p_sh_q, p_sh_d;
  samp_mode_e mode_sh_q, mode_sh_d;
  logic [4:0] samples_q, samples_d;
  logic       bit_q, bit_d;
  logic       done_q, done_d;
  logic       noise_q, noise_d;

  logic [1:0] k;
  cnt_t       mid, tap_lo, tap_hi;
  logic       in_tap, last_tap, wrap;
  logic [2:0] tap_idx;
  logic [4:0] samples_cap;
  logic       vote, noise;

  // Tap window derived from the shadowed ratio/mode so mid-bit input changes wait for the next bit.
  always_comb begin
    case (mode_sh_q)
      SAMP_1TAP: k = 2'd0;
      SAMP_5TAP: k = 2'd2;
      default:   k = 2'd1;
    endcase
    if (p_sh_q == cnt_t'(PRESCALE_4)) k = 2'd0;
    mid      = (p_sh_q >> 1) - cnt_t'(1);
    tap_lo   = mid - cnt_t'(k);
    tap_hi   = mid + cnt_t'(k);
    in_tap   = (edge_q >= tap_lo) && (edge_q <= tap_hi);
    last_tap = (edge_q == tap_hi);
    wrap     = (edge_q == p_sh_q - cnt_t'(1));
    tap_idx  = 3'(edge_q - tap_lo);
  end

  // Vote on the sample set including the tap captured this cycle, so results land with the done pulse.
  always_comb begin
    samples_cap = samples_q;
    if (in_tap) samples_cap[tap_idx] = RX_IN;
  end

  rx_majority_vote u_vote (
    .samples_i (samples_cap),
    .k_i       (k),
    .vote_o    (vote),
    .noise_o   (noise)
  );

  always_comb begin
    edge_d    = edge_q;
    samples_d = samples_q;
    bit_d     = bit_q;
    noise_d   = noise_q;
    done_d    = 1'b0;
    p_sh_d    = p_sh_q;
    mode_sh_d = mode_sh_q;
    if (!samp_en) begin
      edge_d    = '0;
      samples_d = '0;
    end else if (bit_start) begin
      edge_d    = '0;
      samples_d = '0;
      p_sh_d    = prescale;
      mode_sh_d = samp_mode_e'(samp_mode);
    end else begin
      samples_d = samples_cap;
      if (last_tap) begin
        done_d  = 1'b1;
        bit_d   = vote;
        noise_d = noise;
      end
      if (wrap) begin
        edge_d    = '0;
        p_sh_d    = prescale;
        mode_sh_d = samp_mode_e'(samp_mode);
      end else begin
        edge_d = edge_q + cnt_t'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      edge_q    <= '0;
      samples_q <= '0;
      bit_q     <= 1'b1;
      done_q    <= 1'b0;
      noise_q   <= 1'b0;
      p_sh_q    <= cnt_t'(PRESCALE_DEF);
      mode_sh_q <= MODE_DEF;
    end else begin
      edge_q    <= edge_d;
      samples_q <= samples_d;
      bit_q     <= bit_d;
      done_q    <= done_d;
      noise_q   <= noise_d;
      p_sh_q    <= p_sh_d;
      mode_sh_q <= mode_sh_d;
    end
  end

  assign edge_count    = edge_q;
  assign sampled_bit   = bit_q;
  assign sampling_done = done_q;
  assign noise_err     = noise_q;

endmodule

// File: tb/tb_rx_oversample_sampler.sv
// Scoreboard bench for rx_oversample_sampler: expected bit results are queued
// as each bit is stimulated and checked when sampling_done pulses.
module tb_rx_oversample_sampler;

  logic       CLK = 1'b0;
  logic       RST;
  logic [5:0] prescale;
  logic [1:0] samp_mode;
  logic       samp_en;
  logic       bit_start;
  logic       RX_IN;
  logic [5:0] edge_count;
  logic       sampled_bit;
  logic       sampling_done;
  logic       noise_err;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    int   done_edge;
    logic bitv;
    logic noise;
  } exp_t;

  exp_t scb[$];

  rx_oversample_sampler #(.PRESCALE_WD(6)) dut (
    .CLK           (CLK),
    .RST           (RST),
    .prescale      (prescale),
    .samp_mode     (samp_mode),
    .samp_en       (samp_en),
    .bit_start     (bit_start),
    .RX_IN         (RX_IN),
    .edge_count    (edge_count),
    .sampled_bit   (sampled_bit),
    .sampling_done (sampling_done),
    .noise_err     (noise_err)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic start_bit(input int p, input logic [1:0] m);
    prescale  = 6'(p);
    samp_mode = m;
    samp_en   = 1'b1;
    bit_start = 1'b1;
    tick();
    bit_start = 1'b0;
  endtask

  task automatic push_exp(input int done_edge, input logic b, input logic n);
    exp_t e;
    e.done_edge = done_edge;
    e.bitv      = b;
    e.noise     = n;
    scb.push_back(e);
  endtask

  // Drives RX_IN = base except ~base at edge 'glitch'; optionally changes prescale at edge chg_edge.
  task automatic wait_done(input string name, input logic base, input int glitch,
                           input int chg_edge, input int new_p);
    exp_t e;
    bit   got = 0;
    for (int c = 0; c < 80; c++) begin
      if (sampling_done === 1'b1) begin
        got = 1;
        break;
      end
      if (chg_edge >= 0 && int'(edge_count) == chg_edge) prescale = 6'(new_p);
      RX_IN = (int'(edge_count) == glitch) ? ~base : base;
      tick();
    end
    e = scb.pop_front();
    if (!got) begin
      n_cmp++; n_err++;
      $display("FAIL %s timeout: no sampling_done, required at edge %0d", name, e.done_edge);
    end else begin
      n_cmp++;
      if (int'(edge_count) !== e.done_edge) begin
        n_err++;
        $display("FAIL %s done_edge: got %0d required %0d", name, edge_count, e.done_edge);
      end
      n_cmp++;
      if (sampled_bit !== e.bitv) begin
        n_err++;
        $display("FAIL %s sampled_bit: got %b required %b", name, sampled_bit, e.bitv);
      end
      n_cmp++;
      if (noise_err !== e.noise) begin
        n_err++;
        $display("FAIL %s noise_err: got %b required %b", name, noise_err, e.noise);
      end
      RX_IN = base;
      tick();
    end
  endtask

  task automatic tick_until_edge(input int target);
    for (int c = 0; c < 40; c++) begin
      if (int'(edge_count) == target) break;
      tick();
    end
  endtask

  task automatic test_reset();
    RST = 1'b0; samp_en = 1'b0; bit_start = 1'b0; RX_IN = 1'b1;
    prescale = 6'd8; samp_mode = 2'b01;
    tick(); tick();
    n_cmp++; if (edge_count !== 6'd0) begin n_err++; $display("FAIL reset edge_count: got %0d required 0", edge_count); end
    n_cmp++; if (sampled_bit !== 1'b1) begin n_err++; $display("FAIL reset sampled_bit: got %b required 1", sampled_bit); end
    n_cmp++; if (sampling_done !== 1'b0) begin n_err++; $display("FAIL reset sampling_done: got %b required 0", sampling_done); end
    n_cmp++; if (noise_err !== 1'b0) begin n_err++; $display("FAIL reset noise_err: got %b required 0", noise_err); end
    RST = 1'b1;
    tick();
  endtask

  task automatic test_three_tap();
    start_bit(8, 2'b01);
    push_exp(5, 1'b1, 1'b0);
    wait_done("p8_3tap_ones", 1'b1, -1, -1, 0);
  endtask

  task automatic test_five_tap_glitch();
    start_bit(16, 2'b10);
    push_exp(10, 1'b0, 1'b1);
    wait_done("p16_5tap_glitch", 1'b0, 6, -1, 0);
  endtask

  task automatic test_samp_en_low();
    samp_en = 1'b0;
    tick(); tick(); tick();
    n_cmp++; if (edge_count !== 6'd0) begin n_err++; $display("FAIL en_low edge_count: got %0d required 0", edge_count); end
    n_cmp++; if (sampling_done !== 1'b0) begin n_err++; $display("FAIL en_low sampling_done: got %b required 0", sampling_done); end
    n_cmp++; if (sampled_bit !== 1'b0) begin n_err++; $display("FAIL en_low sampled_bit hold: got %b required 0", sampled_bit); end
    n_cmp++; if (noise_err !== 1'b1) begin n_err++; $display("FAIL en_low noise_err hold: got %b required 1", noise_err); end
  endtask

  task automatic test_prescale4();
    start_bit(4, 2'b10);
    push_exp(2, 1'b1, 1'b0);
    wait_done("p4_forced_1tap_a", 1'b0, 1, -1, 0);
    // Lands at edge 3, so this bit_start coincides with the wrap.
    start_bit(4, 2'b10);
    push_exp(2, 1'b0, 1'b0);
    wait_done("p4_forced_1tap_b", 1'b1, 1, -1, 0);
  endtask

  task automatic test_mode11();
    start_bit(16, 2'b11);
    push_exp(9, 1'b1, 1'b1);
    wait_done("p16_mode11", 1'b1, 6, -1, 0);
  endtask

  task automatic test_shadow_change();
    start_bit(8, 2'b10);
    push_exp(6, 1'b1, 1'b0);
    wait_done("shadow_bit1", 1'b1, -1, 3, 16);
    n_cmp++; if (edge_count !== 6'd7) begin n_err++; $display("FAIL shadow pre_wrap edge: got %0d required 7", edge_count); end
    tick();
    n_cmp++; if (edge_count !== 6'd0) begin n_err++; $display("FAIL shadow wrap edge: got %0d required 0", edge_count); end
    push_exp(10, 1'b1, 1'b1);
    wait_done("shadow_bit2", 1'b1, 8, -1, 0);
  endtask

  task automatic test_bit_start_restart();
    start_bit(8, 2'b01);
    RX_IN = 1'b1;
    tick_until_edge(4);
    bit_start = 1'b1;
    tick();
    bit_start = 1'b0;
    n_cmp++; if (edge_count !== 6'd0) begin n_err++; $display("FAIL restart edge_count: got %0d required 0", edge_count); end
    n_cmp++; if (sampling_done !== 1'b0) begin n_err++; $display("FAIL restart suppressed_done: got %b required 0", sampling_done); end
    push_exp(5, 1'b0, 1'b0);
    wait_done("restart_new_bit", 1'b0, -1, -1, 0);
  endtask

  task automatic test_back_to_back();
    logic bits [3];
    bits[0] = 1'b1; bits[1] = 1'b0; bits[2] = 1'b1;
    start_bit(8, 2'b00);
    for (int b = 0; b < 3; b++) begin
      push_exp(4, bits[b], 1'b0);
      wait_done("back_to_back", bits[b], -1, -1, 0);
    end
  endtask

  task automatic test_reset_midbit();
    start_bit(8, 2'b01);
    push_exp(5, 1'b0, 1'b1);
    wait_done("pre_reset_bit", 1'b0, 3, -1, 0);
    start_bit(8, 2'b01);
    tick_until_edge(3);
    RST = 1'b0;
    tick();
    n_cmp++; if (edge_count !== 6'd0) begin n_err++; $display("FAIL midreset edge_count: got %0d required 0", edge_count); end
    n_cmp++; if (sampled_bit !== 1'b1) begin n_err++; $display("FAIL midreset sampled_bit: got %b required 1", sampled_bit); end
    n_cmp++; if (noise_err !== 1'b0) begin n_err++; $display("FAIL midreset noise_err: got %b required 0", noise_err); end
    n_cmp++; if (sampling_done !== 1'b0) begin n_err++; $display("FAIL midreset sampling_done: got %b required 0", sampling_done); end
    RST = 1'b1;
    prescale  = 6'd16;
    samp_mode = 2'b10;
    // Shadows are back at their defaults (8, 3 taps) until the first wrap.
    push_exp(5, 1'b0, 1'b0);
    wait_done("post_reset_bit", 1'b0, -1, -1, 0);
  endtask

  initial begin
    test_reset();
    test_three_tap();
    test_five_tap_glitch();
    test_samp_en_low();
    test_prescale4();
    test_mode11();
    test_shadow_change();
    test_bit_start_restart();
    test_back_to_back();
    test_reset_midbit();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
